// File: rtl/gpio_pixel_tx.sv
// RGB pixel stream to GPIO word-burst transmitter: packs 4 pixels per channel, emits R/G/B words.
// Optional: define GPIO_TX_STALL_EN to add the gpio_stall input that freezes emission.
module gpio_pixel_tx #(
  parameter int NUM_WORDS  = 40000,
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef GPIO_TX_STALL_EN
  input  logic        gpio_stall,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic [31:0] GPIO,
  output logic        GPIOEnR,
  output logic        GPIOEnG,
  output logic        GPIOEnB,
  output logic        GPIOEn,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int PW = $clog2(4 * NUM_WORDS + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_R, S_G, S_B, S_GAP} state_t;

  state_t        state;
  logic          stall;
  logic [31:0]   pack_r, pack_g, pack_b;
  logic [31:0]   hold_r, hold_g, hold_b;
  logic [31:0]   pk_r_nxt, pk_g_nxt, pk_b_nxt;
  logic [1:0]    p;
  logic          pack_full, hold_valid, hold_valid_nxt;
  logic [CW-1:0] word_cnt;
  logic [PW-1:0] pix_cnt;
  logic [GW-1:0] gap_cnt;
  logic          first_flag;
  logic [31:0]   gpio_q;
  logic          en_r_q, en_g_q, en_b_q, en_sof_q;
  logic          accept, group_done, b_fire, hold_free, xfer;
  logic [31:0]   r_word;

`ifdef GPIO_TX_STALL_EN
  assign stall = gpio_stall;
`else
  assign stall = 1'b0;
`endif

  assign in_ready   = (state != S_IDLE) && !pack_full && (pix_cnt < PW'(4 * NUM_WORDS));
  assign accept     = in_valid && in_ready;
  assign group_done = accept && (p == 2'd3);
  // Hold is released by the edge that ends an unstalled B word, so a group may refill it on that same edge.
  assign b_fire     = (state == S_B) && !stall;
  assign hold_free  = !hold_valid || b_fire;
  assign xfer       = hold_free && (pack_full || group_done);
  assign hold_valid_nxt = xfer || (hold_valid && !b_fire);
  assign r_word     = xfer ? pk_r_nxt : hold_r;

  always_comb begin
    pk_r_nxt = pack_r;
    pk_g_nxt = pack_g;
    pk_b_nxt = pack_b;
    if (accept) begin
      pk_r_nxt[{p, 3'b000} +: 8] = in_r;
      pk_g_nxt[{p, 3'b000} +: 8] = in_g;
      pk_b_nxt[{p, 3'b000} +: 8] = in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_r     <= '0;
      pack_g     <= '0;
      pack_b     <= '0;
      hold_r     <= '0;
      hold_g     <= '0;
      hold_b     <= '0;
      p          <= '0;
      pack_full  <= 1'b0;
      hold_valid <= 1'b0;
      pix_cnt    <= '0;
    end else if (state == S_IDLE) begin
      p          <= '0;
      pack_full  <= 1'b0;
      hold_valid <= 1'b0;
      pix_cnt    <= '0;
    end else begin
      if (accept) begin
        pack_r  <= pk_r_nxt;
        pack_g  <= pk_g_nxt;
        pack_b  <= pk_b_nxt;
        p       <= p + 2'd1;
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (xfer) begin
        hold_r <= pk_r_nxt;
        hold_g <= pk_g_nxt;
        hold_b <= pk_b_nxt;
      end
      pack_full  <= xfer ? 1'b0 : (pack_full || group_done);
      hold_valid <= hold_valid_nxt;
    end
  end

  // Output registers are loaded together with the state, so each state shows its own word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      gap_cnt    <= '0;
      first_flag <= 1'b0;
      gpio_q     <= '0;
      en_r_q     <= 1'b0;
      en_g_q     <= 1'b0;
      en_b_q     <= 1'b0;
      en_sof_q   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        gpio_q     <= '0;
        en_r_q     <= 1'b0;
        en_g_q     <= 1'b0;
        en_b_q     <= 1'b0;
        en_sof_q   <= 1'b0;
        word_cnt   <= '0;
        first_flag <= 1'b1;
        if (start) begin
          state <= S_WAIT;
          busy  <= 1'b1;
        end
      end else if (!stall) begin
        case (state)
          S_R: begin
            state    <= S_G;
            gpio_q   <= hold_g;
            en_r_q   <= 1'b0;
            en_sof_q <= 1'b0;
            en_g_q   <= 1'b1;
          end
          S_G: begin
            state  <= S_B;
            gpio_q <= hold_b;
            en_g_q <= 1'b0;
            en_b_q <= 1'b1;
          end
          S_B: begin
            gpio_q   <= '0;
            en_b_q   <= 1'b0;
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == CW'(NUM_WORDS - 1)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state   <= S_GAP;
              gap_cnt <= GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
            end else if (hold_valid_nxt) begin
              state      <= S_R;
              gpio_q     <= r_word;
              en_r_q     <= 1'b1;
              en_sof_q   <= first_flag;
              first_flag <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end
          default: begin
            if (state == S_GAP && gap_cnt != '0) begin
              gap_cnt <= gap_cnt - 1'b1;
            end else if (hold_valid_nxt) begin
              state      <= S_R;
              gpio_q     <= r_word;
              en_r_q     <= 1'b1;
              en_sof_q   <= first_flag;
              first_flag <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end
        endcase
      end
    end
  end

  assign GPIO    = stall ? 32'd0 : gpio_q;
  assign GPIOEnR = en_r_q && !stall;
  assign GPIOEnG = en_g_q && !stall;
  assign GPIOEnB = en_b_q && !stall;
  assign GPIOEn  = en_sof_q && !stall;

endmodule

// File: doc/gpio_pixel_tx.md
Name: gpio_pixel_tx

Overview:
- Transmit end of the processor GPIO pixel-output interface.
- Accepts a stream of RGB pixels (one 8-bit sample per channel), packs 4 pixels per channel into 32-bit words, and drives GPIO as R, G, B word bursts with per-channel strobes.
- Pulses a start-of-frame flag on the first word of each frame.
- Sits between a pixel source (memory reader/processor datapath) and the board GPIO / capture bench.

Parameters:
- NUM_WORDS, 40000, B-word count per frame; pixels per frame = 4*NUM_WORDS; must be ≥ 1.
- GAP_CYCLES, 0, idle cycles inserted after each B word before the next R word.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; sampled in IDLE, begins a frame
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid & in_ready at rising edge
- in_r  in  8  red sample
- in_g  in  8  green sample
- in_b  in  8  blue sample
- GPIO  out  32  packed word; pixel k of group at bits [8k+7:8k], k = 0..3 (first accepted pixel in [7:0])
- GPIOEnR  out  1  GPIO holds red word
- GPIOEnG  out  1  GPIO holds green word
- GPIOEnB  out  1  GPIO holds blue word
- GPIOEn  out  1  one-cycle start-of-frame marker, coincident with the frame's first GPIOEnR
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the frame's last B word

Behaviour:
- Reset (async, immediate): all outputs 0; GPIO = 0; pack/hold registers, counters and FSM cleared; state IDLE. Reset mid-frame abandons the frame; no done pulse.
- IDLE: in_ready = 0, busy = 0. start = 1 moves to RUN next cycle. The word counter and pack index clear. first_flag is set.
- Packing stage:
  - Holds three 32-bit pack registers and a 2-bit index p.
  - Each accepted pixel writes in_r/in_g/in_b to byte p of the R/G/B pack registers; p increments and wraps 3→0.
  - When the 4th pixel is accepted, the group is full and transfers to the hold registers.
  - If hold is empty, or is being freed in the same cycle by the B-word emission, transfer happens on that edge.
  - Otherwise pack is marked full and transfers when hold frees.
- in_ready: 1 in RUN when pack is not full and the frame's pixel count < 4*NUM_WORDS; otherwise 0.
- Output FSM (hold valid):
  - EMIT_R: GPIO = hold_R, GPIOEnR = 1; GPIOEn = first_flag; first_flag clears.
  - EMIT_G: GPIO = hold_G, GPIOEnG = 1.
  - EMIT_B: GPIO = hold_B, GPIOEnB = 1; word counter increments; hold frees.
  - After EMIT_B: go to GAP for GAP_CYCLES cycles with all strobes 0, then EMIT_R if hold is valid, else WAIT.
- Strobes are one-hot or all-zero. GPIO is registered and equals 0 whenever no strobe is high.
- Minimum latency: 4th pixel accepted at edge N → GPIOEnR high in cycle N+1. R, G and B occupy three consecutive cycles.
- Back-to-back groups with GAP_CYCLES = 0: R,G,B,R,G,B… with no bubbles, provided input keeps pace (≥4 pixels per 3 cycles not required; bubbles allowed as WAIT).
- Frame end: the B word that brings the counter to NUM_WORDS returns the FSM to IDLE. done = 1 in the following cycle; busy drops in the same cycle.
- start asserted while busy: ignored.
- start held high at frame end: the next frame begins from IDLE and GPIOEn fires again.
- Counter width: $clog2(NUM_WORDS+1); no wrap within a frame.

Optional Feature:
- Macro: GPIO_TX_STALL_EN.
- Defined: adds input port gpio_stall (1 bit).
  - While gpio_stall = 1, the output FSM holds its state and GPIO/strobes are forced to 0.
  - GAP countdown freezes.
  - The held word is re-emitted when the stall releases; no word is lost or duplicated.
  - Packing continues until pack is full.
- Not defined: no port; emission is never stalled.

Test Plan:
- Reset/idle: assert rst with in_valid = 1 → all outputs 0, in_ready = 0; stays so until start.
- Single group, NUM_WORDS = 1: pixels (R,G,B) = (01,11,21),(02,12,22),(03,13,23),(04,14,24), then:
  - GPIO = 04030201 with GPIOEnR and GPIOEn both high.
  - Next cycle GPIO = 14131211 with GPIOEnG.
  - Next cycle GPIO = 24232221 with GPIOEnB.
  - done pulses the cycle after.
- Streaming, NUM_WORDS = 3, GAP_CYCLES = 0, in_valid always high:
  - Exactly 3 R/G/B triplets; GPIOEn only on the first.
  - in_ready = 0 after 12 pixels.
  - done once.
- Backpressure: hold the source idle after pixel 6 for 10 cycles → no strobes during the gap; group 2 emits correctly once pixels 7–8 arrive.
- Mid-frame reset: assert rst during EMIT_G → strobes drop immediately; no done; a new start produces GPIOEn with the fresh first word.
- GPIO_TX_STALL_EN: gpio_stall = 1 for 5 cycles during EMIT_R → zero strobes for 5 cycles, then the same R word, then G and B; the total word count is unchanged.
